polirv_ifetch: RTL and testbench
================================

POLIRV_IFETCH -- requirements
Module: polirv_ifetch

Interface
REQ-001 The module SHALL have parameter I_ADDR_BITS, default 6, meaning the width of the byte-addressed program counter and instruction memory address.
REQ-002 The module SHALL have parameter FQ_DEPTH, default 4, meaning the fetch queue entry count; legal values are powers of two from 2 to 16.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset; it is word aligned.
REQ-004 The module SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have a port rst_n, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 The module SHALL have a port i_mem_addr, output, I_ADDR_BITS bits: the instruction memory address, equal to the current PC.
REQ-007 The module SHALL have a port i_mem_data, input, 32 bits: the instruction word, combinationally valid for i_mem_addr in the same cycle.
REQ-008 The module SHALL have a port redirect, input, 1 bit: taken branch or jump; flushes and reloads the PC.
REQ-009 The module SHALL have a port redirect_pc, input, I_ADDR_BITS bits: the new fetch address.
REQ-010 The module SHALL have a port dec_ready, input, 1 bit: the decode stage accepts the head instruction.
REQ-011 The module SHALL have a port dec_valid, output, 1 bit: the head instruction is valid.
REQ-012 The module SHALL have ports dec_instr, output, 32 bits, and dec_pc, output, I_ADDR_BITS bits: the head instruction and its address.
REQ-013 The module SHALL have a port fq_count, output, $clog2(FQ_DEPTH)+1 bits: the queue occupancy.
REQ-014 The module SHALL have a port misalign, output, 1 bit: sticky flag, set by a redirect with redirect_pc[1:0] != 0.

Function
REQ-015 Push condition SHALL be: no redirect AND (fq_count < FQ_DEPTH OR pop this cycle); on push, {i_mem_data, PC} enters the tail and PC <= PC + 4.
REQ-016 PC increment SHALL wrap modulo 2^I_ADDR_BITS with no flag.
REQ-017 Pop SHALL occur when dec_valid AND dec_ready; the head advances and dec_instr/dec_pc show the next entry in the following cycle.
REQ-018 Simultaneous push and pop at full SHALL leave fq_count unchanged; at empty they are handled per REQ-027/REQ-028.
REQ-019 Read and write pointers SHALL wrap modulo FQ_DEPTH; there is no overflow or underflow under any input sequence.
REQ-020 redirect SHALL have priority over push and pop: the queue is emptied (fq_count <= 0) and PC <= {redirect_pc[I_ADDR_BITS-1:2], 2'b00}, with no push that cycle.
REQ-021 dec_valid SHALL be forced to 0 in a redirect cycle, and dec_ready SHALL be ignored.
REQ-022 A redirect with redirect_pc[1:0] != 0 SHALL set misalign, which holds until reset.
REQ-023 Back-to-back redirects SHALL each take effect; the last one determines the PC.
REQ-024 With dec_ready held at 0, the queue SHALL fill to FQ_DEPTH and then PC SHALL hold with dec_instr/dec_pc stable.

Reset
REQ-025 While rst_n = 1 at a clock edge, the module SHALL load PC <= RESET_PC and set fq_count = 0, dec_valid = 0, misalign = 0, dec_instr = 0 and dec_pc = 0 (both from cleared storage); reset overrides redirect and dec_ready.
REQ-026 A reset asserted mid-stream SHALL discard all queued entries, and fetch SHALL resume at RESET_PC in the first cycle after rst_n = 0.

Configuration
REQ-027 With macro IFETCH_BYPASS_EN defined, when fq_count = 0 and no redirect, the module SHALL drive dec_valid = 1, dec_instr = i_mem_data and dec_pc = PC combinationally; if dec_ready = 1, the instruction SHALL be consumed directly (no push) and PC <= PC + 4, giving zero-cycle fetch latency.
REQ-028 Without IFETCH_BYPASS_EN, dec_valid SHALL derive only from fq_count != 0, and the first instruction after reset or redirect SHALL appear one cycle after its fetch.

Verification
REQ-029 Reset, then dec_ready = 1 with memory word[n] = 0x00000013 + n: dec_pc SHALL sequence 0, 4, 8, ... with matching dec_instr, and the first valid SHALL be in cycle 1 (cycle 0 with IFETCH_BYPASS_EN).
REQ-030 Hold dec_ready = 0 with FQ_DEPTH = 4: fq_count SHALL reach 4 and i_mem_addr SHALL hold at 0x10; on release, pops SHALL return PCs 0, 4, 8, 0xC in order without gaps.
REQ-031 Redirect to 0x20 while fq_count = 3: the next cycle SHALL show fq_count = 0 and i_mem_addr = 0x20, and the first dec_pc SHALL be 0x20; no stale entry SHALL be delivered.
REQ-032 Redirect to 0x22: PC SHALL become 0x20, and misalign SHALL rise and stay at 1 until rst_n.
REQ-033 Free-run from PC 0x3C (I_ADDR_BITS = 6): the next PC SHALL be 0x00, with no error.
REQ-034 Assert rst_n for 1 cycle with the queue full and a simultaneous redirect: fq_count SHALL be 0, PC SHALL equal RESET_PC, and misalign SHALL be 0.

Source files
------------

// File: rtl/polirv_ifetch.sv
// Instruction fetch stage: PC register plus a small fetch queue toward decode.
// Optional zero-latency empty-queue bypass is enabled by defining IFETCH_BYPASS_EN.
module polirv_ifetch #(
  parameter int I_ADDR_BITS = 6,
  parameter int FQ_DEPTH    = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [I_ADDR_BITS-1:0]       i_mem_addr,
  input  logic [31:0]                  i_mem_data,
  input  logic                         redirect,
  input  logic [I_ADDR_BITS-1:0]       redirect_pc,
  input  logic                         dec_ready,
  output logic                         dec_valid,
  output logic [31:0]                  dec_instr,
  output logic [I_ADDR_BITS-1:0]       dec_pc,
  output logic [$clog2(FQ_DEPTH):0]    fq_count,
  output logic                         misalign
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]          DEPTH_C    = CW'(FQ_DEPTH);
  localparam logic [I_ADDR_BITS-1:0] RESET_PC_C = I_ADDR_BITS'(RESET_PC);
  localparam logic [I_ADDR_BITS-1:0] PC_STEP_C  = I_ADDR_BITS'(4);

  typedef struct packed {
    logic [31:0]            instr;
    logic [I_ADDR_BITS-1:0] pc;
  } fq_entry_t;

  fq_entry_t              r_mem [FQ_DEPTH];
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [I_ADDR_BITS-1:0] r_pc;
  logic                   r_misalign;

  fq_entry_t w_head;
  logic      w_empty;
  logic      w_full;
  logic      w_pop;
  logic      w_q_pop;
  logic      w_bypass_take;
  logic      w_push;
  logic      w_pc_adv;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    w_empty   = (r_count == '0);
    w_full    = (r_count == DEPTH_C);
    dec_valid = w_empty ? 1'b0 : !redirect;
    dec_instr = w_head.instr;
    dec_pc    = w_head.pc;
`ifdef IFETCH_BYPASS_EN
    // Empty queue: present the word being fetched right now.
    if (w_empty && !redirect && !rst_n) begin
      dec_valid = 1'b1;
      dec_instr = i_mem_data;
      dec_pc    = r_pc;
    end
`endif
    w_pop         = dec_valid && dec_ready;
    w_q_pop       = w_pop && !w_empty;
    w_bypass_take = w_pop && w_empty;
    w_push        = !redirect && (!w_full || w_pop) && !w_bypass_take;
    w_pc_adv      = w_push || w_bypass_take;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pc       <= RESET_PC_C;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      // NOTE: queue storage is reset so dec_instr/dec_pc read zero after reset.
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_pc     <= {redirect_pc[I_ADDR_BITS-1:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{instr: i_mem_data, pc: r_pc};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_q_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_q_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // PC wraps naturally at 2^I_ADDR_BITS.
      if (w_pc_adv) begin
        r_pc <= r_pc + PC_STEP_C;
      end
    end
  end

  assign i_mem_addr = r_pc;
  assign fq_count   = r_count;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_polirv_ifetch.sv
// Scoreboard bench for polirv_ifetch: expected fetch PCs are queued per scenario
// and checked as decode accepts each instruction. Memory word[n] = 0x13 + n.
module tb_polirv_ifetch;

  localparam int IAB = 6;
  localparam int FQD = 4;
  localparam int RPC = 0;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           redirect = 1'b0;
  logic [IAB-1:0] redirect_pc = '0;
  logic           dec_ready = 1'b0;
  logic [IAB-1:0] i_mem_addr;
  logic [31:0]    i_mem_data;
  logic           dec_valid;
  logic [31:0]    dec_instr;
  logic [IAB-1:0] dec_pc;
  logic [2:0]     fq_count;
  logic           misalign;

  int             n_tests = 0;
  int             n_fail = 0;
  logic [IAB-1:0] sb_q[$];
  bit             sb_on = 1'b0;
  logic [IAB-1:0] exp_pc;
  logic [31:0]    exp_instr;
  bit             ok;
  int             first;

  polirv_ifetch #(.I_ADDR_BITS(IAB), .FQ_DEPTH(FQD), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .fq_count    (fq_count),
    .misalign    (misalign)
  );

  assign i_mem_data = 32'h13 + 32'(i_mem_addr >> 2);

  always #5 clk = ~clk;

  // Scoreboard consumer at the negedge, then advance to just after the next posedge.
  task automatic cycle();
    @(negedge clk);
    if (sb_on && !rst_n && dec_valid && dec_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no delivery", dec_pc);
      end else begin
        exp_pc    = sb_q.pop_front();
        exp_instr = 32'h13 + 32'(exp_pc >> 2);
        n_tests++;
        if (dec_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL sb_pc: got %h, expected %h", dec_pc, exp_pc);
        end
        n_tests++;
        if (dec_instr !== exp_instr) begin
          n_fail++;
          $display("FAIL sb_instr: got %h, expected %h", dec_instr, exp_instr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int budget, output bit done);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) cycle();
    done = (sb_q.size() == 0);
    sb_on = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b1; redirect = 1'b0; dec_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 6'h22; dec_ready = 1'b1;
    cycle();
    cycle();
    redirect = 1'b0;
    #1;
    n_tests++; if (fq_count !== 3'd0)     begin n_fail++; $display("FAIL rst_count: got %0d, expected 0", fq_count); end
    n_tests++; if (i_mem_addr !== 6'(RPC)) begin n_fail++; $display("FAIL rst_pc: got %h, expected %h", i_mem_addr, 6'(RPC)); end
    n_tests++; if (misalign !== 1'b0)     begin n_fail++; $display("FAIL rst_misalign: got %b, expected 0", misalign); end
    n_tests++; if (dec_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", dec_valid); end
    n_tests++; if (dec_instr !== 32'h0)   begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", dec_instr); end
    n_tests++; if (dec_pc !== 6'h0)       begin n_fail++; $display("FAIL rst_dec_pc: got %h, expected 0", dec_pc); end
  endtask

  task automatic test_stream();
    for (int n = 0; n < 8; n++) sb_q.push_back(6'(4 * n));
    sb_on = 1'b1; dec_ready = 1'b1; rst_n = 1'b0; first = -1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
      #1;
      if (dec_valid && first < 0) first = c;
      cycle();
    end
    n_tests++; if (first !== (BYPASS ? 0 : 1)) begin n_fail++; $display("FAIL stream_first_valid: got cycle %0d, expected %0d", first, BYPASS ? 0 : 1); end
    run_until_empty(4, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_drain: got leftover entries, expected all delivered"); end
  endtask

  task automatic test_fill();
    do_reset();
    repeat (6) cycle();
    #1;
    n_tests++; if (fq_count !== 3'd4)   begin n_fail++; $display("FAIL fill_count: got %0d, expected 4", fq_count); end
    n_tests++; if (i_mem_addr !== 6'h10) begin n_fail++; $display("FAIL fill_pc_hold: got %h, expected 10", i_mem_addr); end
    n_tests++; if (dec_valid !== 1'b1)  begin n_fail++; $display("FAIL fill_valid: got %b, expected 1", dec_valid); end
    cycle();
    #1;
    n_tests++; if (dec_pc !== 6'h00)     begin n_fail++; $display("FAIL fill_head_stable: got %h, expected 00", dec_pc); end
    n_tests++; if (i_mem_addr !== 6'h10) begin n_fail++; $display("FAIL fill_pc_stable: got %h, expected 10", i_mem_addr); end
    for (int n = 0; n < 6; n++) sb_q.push_back(6'(4 * n));
    sb_on = 1'b1; dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL fill_no_gap: got valid %b at cycle %0d, expected 1", dec_valid, c); end
      cycle();
    end
    run_until_empty(2, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_drain: got leftover entries, expected all delivered"); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) cycle();
    #1;
    n_tests++; if (fq_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count: got %0d, expected 3", fq_count); end
    redirect = 1'b1; redirect_pc = 6'h20; dec_ready = 1'b1;
    #1;
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_forced: got %b, expected 0", dec_valid); end
    cycle();
    redirect = 1'b0;
    sb_q.push_back(6'h20); sb_q.push_back(6'h24); sb_q.push_back(6'h28);
    sb_on = 1'b1;
    #1;
    n_tests++; if (fq_count !== 3'd0)    begin n_fail++; $display("FAIL redir_count: got %0d, expected 0", fq_count); end
    n_tests++; if (i_mem_addr !== 6'h20) begin n_fail++; $display("FAIL redir_pc: got %h, expected 20", i_mem_addr); end
    run_until_empty(10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL redir_drain: got leftover entries, expected all delivered"); end
  endtask

  task automatic test_misalign();
    dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 6'h22;
    cycle();
    redirect = 1'b0;
    #1;
    n_tests++; if (i_mem_addr !== 6'h20) begin n_fail++; $display("FAIL misal_pc: got %h, expected 20", i_mem_addr); end
    n_tests++; if (misalign !== 1'b1)    begin n_fail++; $display("FAIL misal_set: got %b, expected 1", misalign); end
    redirect = 1'b1; redirect_pc = 6'h08;
    cycle();
    redirect_pc = 6'h30;
    cycle();
    redirect = 1'b0;
    #1;
    n_tests++; if (i_mem_addr !== 6'h30) begin n_fail++; $display("FAIL b2b_redir_pc: got %h, expected 30", i_mem_addr); end
    sb_q.push_back(6'h30); sb_q.push_back(6'h34);
    sb_on = 1'b1; dec_ready = 1'b1;
    run_until_empty(10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got leftover entries, expected all delivered"); end
    repeat (3) cycle();
    #1;
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL misal_sticky: got %b, expected 1", misalign); end
  endtask

  task automatic test_wrap();
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 6'h3C;
    cycle();
    redirect = 1'b0;
    #1;
    n_tests++; if (i_mem_addr !== 6'h3C) begin n_fail++; $display("FAIL wrap_start: got %h, expected 3c", i_mem_addr); end
    sb_q.push_back(6'h3C); sb_q.push_back(6'h00); sb_q.push_back(6'h04);
    sb_on = 1'b1;
    cycle();
    #1;
    n_tests++; if (i_mem_addr !== 6'h00) begin n_fail++; $display("FAIL wrap_pc: got %h, expected 00", i_mem_addr); end
    run_until_empty(10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_drain: got leftover entries, expected all delivered"); end
  endtask

  task automatic test_reset_full();
    redirect = 1'b0; dec_ready = 1'b0;
    repeat (6) cycle();
    #1;
    n_tests++; if (fq_count !== 3'd4) begin n_fail++; $display("FAIL rf_pre_full: got %0d, expected 4", fq_count); end
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL rf_pre_misal: got %b, expected 1", misalign); end
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 6'h22; dec_ready = 1'b1;
    cycle();
    rst_n = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    #1;
    n_tests++; if (fq_count !== 3'd0)      begin n_fail++; $display("FAIL rf_count: got %0d, expected 0", fq_count); end
    n_tests++; if (i_mem_addr !== 6'(RPC)) begin n_fail++; $display("FAIL rf_pc: got %h, expected %h", i_mem_addr, 6'(RPC)); end
    n_tests++; if (misalign !== 1'b0)      begin n_fail++; $display("FAIL rf_misal: got %b, expected 0", misalign); end
    n_tests++; if (dec_valid !== BYPASS)   begin n_fail++; $display("FAIL rf_valid: got %b, expected %b", dec_valid, BYPASS); end
    cycle();
    #1;
    n_tests++; if (i_mem_addr !== 6'(RPC + 4)) begin n_fail++; $display("FAIL rf_resume_pc: got %h, expected %h", i_mem_addr, 6'(RPC + 4)); end
    n_tests++; if (fq_count !== 3'd1)          begin n_fail++; $display("FAIL rf_resume_count: got %0d, expected 1", fq_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_misalign();
    test_wrap();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
